// File: rtl/cache_line_fetch_arbiter_broadcast.sv
// Round-robin line-fetch arbiter: one memory read at a time, result broadcast to all caches.
// Latency: grant->mem_req 1 cycle, mem_rsp->bcast_valid 1 cycle, bcast_data one cycle after bcast_valid.
// Backpressure: mem_req held stable until mem_req_ready; clients hold req_valid until req_ready.
module cache_line_fetch_arbiter_broadcast #(
    parameter  int NCLIENTS         = 4,
    parameter  int DWIDTH           = 5,
    parameter  int BLOCK_WIDTH_BITS = 5,
    parameter  int LINE_ADDR_WIDTH  = 15,
    localparam int LINE_W           = DWIDTH * (2 ** BLOCK_WIDTH_BITS)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NCLIENTS-1:0]                 req_valid,
    input  logic [NCLIENTS*LINE_ADDR_WIDTH-1:0] req_addr,
    output logic [NCLIENTS-1:0]                 req_ready,
    output logic [LINE_ADDR_WIDTH-1:0]          bcast_addr,
    output logic                                bcast_valid,
    output logic [LINE_W-1:0]                   bcast_data,
    output logic                                mem_req_valid,
    output logic [LINE_ADDR_WIDTH-1:0]          mem_req_addr,
    input  logic                                mem_req_ready,
    input  logic                                mem_rsp_valid,
    input  logic [LINE_W-1:0]                   mem_rsp_data,
    output logic                                busy
);

    localparam int PTR_W = (NCLIENTS > 1) ? $clog2(NCLIENTS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_BCAST,
        S_HOLD
    } state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic [PTR_W-1:0]           rr_ptr;
    logic [PTR_W-1:0]           grant_idx;
    logic [LINE_ADDR_WIDTH-1:0] addr_saved;
    logic [LINE_W-1:0]          line_reg;

    logic                       any_req;
    logic [PTR_W-1:0]           arb_idx;
    logic [PTR_W-1:0]           cand;

    // Search starts just after the last client whose fetch memory accepted.
    always_comb begin
        any_req = 1'b0;
        arb_idx = '0;
        cand    = '0;
        for (int k = 1; k <= NCLIENTS; k++) begin
            cand = PTR_W'((int'(rr_ptr) + k) % NCLIENTS);
            if (!any_req && req_valid[cand]) begin
                any_req = 1'b1;
                arb_idx = cand;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (any_req)       state_nxt = S_REQ;
            S_REQ:   if (mem_req_ready) state_nxt = S_WAIT;
            S_WAIT:  if (mem_rsp_valid) state_nxt = S_BCAST;
            S_BCAST:                    state_nxt = S_HOLD;
            S_HOLD:                     state_nxt = S_IDLE;
            default:                    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            rr_ptr     <= PTR_W'(NCLIENTS - 1);
            grant_idx  <= '0;
            addr_saved <= '0;
            line_reg   <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && any_req) begin
                grant_idx  <= arb_idx;
                addr_saved <= req_addr[int'(arb_idx)*LINE_ADDR_WIDTH +: LINE_ADDR_WIDTH];
            end
            // Priority only rotates once memory has actually taken the request.
            if (state == S_REQ && mem_req_ready) begin
                rr_ptr <= grant_idx;
            end
            if (state == S_WAIT && mem_rsp_valid) begin
                line_reg <= mem_rsp_data;
            end
        end
    end

    // Every client waiting on the broadcast line is released, not just the granted one.
    always_comb begin
        req_ready = '0;
        if (state == S_BCAST) begin
            for (int i = 0; i < NCLIENTS; i++) begin
                req_ready[i] = req_valid[i] &&
                    (req_addr[i*LINE_ADDR_WIDTH +: LINE_ADDR_WIDTH] == addr_saved);
            end
        end
    end

    assign mem_req_valid = (state == S_REQ);
    assign mem_req_addr  = mem_req_valid ? addr_saved : '0;
    assign bcast_valid   = (state == S_BCAST);
    assign bcast_addr    = bcast_valid ? addr_saved : '0;
    assign bcast_data    = line_reg;
    assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_cache_line_fetch_arbiter_broadcast.sv
// Directed and randomized bench for cache_line_fetch_arbiter_broadcast with a queue-free client/memory model.
module tb_cache_line_fetch_arbiter_broadcast;

    localparam int N  = 4;
    localparam int AW = 15;
    localparam int LW = 5 * 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_ready;
    logic [AW-1:0]   bcast_addr;
    logic            bcast_valid;
    logic [LW-1:0]   bcast_data;
    logic            mem_req_valid;
    logic [AW-1:0]   mem_req_addr;
    logic            mem_req_ready;
    logic            mem_rsp_valid;
    logic [LW-1:0]   mem_rsp_data;
    logic            busy;

    cache_line_fetch_arbiter_broadcast #(
        .NCLIENTS(N), .DWIDTH(5), .BLOCK_WIDTH_BITS(5), .LINE_ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .bcast_addr(bcast_addr), .bcast_valid(bcast_valid), .bcast_data(bcast_data),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int mem_cnt = 0;

    always @(posedge clk) begin
        if (!rst && mem_req_valid && mem_req_ready) mem_cnt++;
    end

    // Client model: what each cache is requesting, and who was last granted by memory.
    bit            cv[N];
    logic [AW-1:0] ca[N];
    int            rr;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]           = cv[i];
            req_addr[i*AW +: AW]   = ca[i];
        end
    endtask

    function automatic int pick();
        for (int k = 1; k <= N; k++) begin
            if (cv[(rr + k) % N]) return (rr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [LW-1:0] rnd_line();
        logic [LW-1:0] r = '0;
        for (int i = 0; i < LW / 32; i++) r = (r << 32) | LW'($urandom);
        return r;
    endfunction

    // Called in an IDLE cycle with requests already driven; returns in the following IDLE cycle.
    task automatic fetch(input int rdy_dly, input int lat, input int drop_c, input int late_c,
                         input bit refill, input logic [LW-1:0] line);
        int            g;
        logic [AW-1:0] a;
        logic [N-1:0]  m;
        g = pick();
        if (g < 0) begin
            chk("no_pending_client", 1, 0);
            return;
        end
        a = ca[g];
        cyc(); #1;
        chk("mem_req_valid", LW'(mem_req_valid), 1);
        chk("mem_req_addr", LW'(mem_req_addr), LW'(a));
        chk("busy_req", LW'(busy), 1);
        for (int d = 0; d < rdy_dly; d++) begin
            cyc(); #1;
            chk("req_hold_valid", LW'(mem_req_valid), 1);
            chk("req_hold_addr", LW'(mem_req_addr), LW'(a));
        end
        mem_req_ready = 1'b1;
        cyc();
        mem_req_ready = 1'b0;
        rr = g;
        if (drop_c >= 0) begin
            cv[drop_c] = 1'b0;
            drive();
        end
        #1;
        chk("wait_no_req", LW'(mem_req_valid), 0);
        chk("wait_no_bcast", LW'(bcast_valid), 0);
        for (int l = 0; l < lat; l++) begin
            cyc(); #1;
            chk("lat_no_bcast", LW'(bcast_valid), 0);
            chk("lat_busy", LW'(busy), 1);
        end
        mem_rsp_data  = line;
        mem_rsp_valid = 1'b1;
        cyc();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = rnd_line();
        if (late_c >= 0) begin
            cv[late_c] = 1'b1;
            ca[late_c] = a;
            drive();
        end
        #1;
        for (int i = 0; i < N; i++) m[i] = cv[i] && (ca[i] == a);
        chk("bcast_valid", LW'(bcast_valid), 1);
        chk("bcast_addr", LW'(bcast_addr), LW'(a));
        chk("req_ready", LW'(req_ready), LW'(m));
        for (int i = 0; i < N; i++) begin
            if (m[i]) begin
                cv[i] = refill;
                ca[i] = AW'($urandom);
            end
        end
        cyc();
        drive();
        #1;
        chk("bcast_data", bcast_data, line);
        chk("hold_no_bcast", LW'(bcast_valid), 0);
        chk("hold_no_ready", LW'(req_ready), 0);
        chk("hold_busy", LW'(busy), 1);
        cyc(); #1;
        chk("idle_busy", LW'(busy), 0);
        chk("idle_no_req", LW'(mem_req_valid), 0);
    endtask

    task automatic clear_clients();
        for (int i = 0; i < N; i++) begin
            cv[i] = 1'b0;
            ca[i] = '0;
        end
        drive();
    endtask

    int cnt0;
    int nv;

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_addr = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data = '0;
        clear_clients();
        rr = N - 1;
        cyc(); cyc();
        rst = 1'b0;
        #1;
        chk("rst_busy", LW'(busy), 0);
        chk("rst_mem_req_valid", LW'(mem_req_valid), 0);
        chk("rst_bcast_valid", LW'(bcast_valid), 0);
        chk("rst_req_ready", LW'(req_ready), 0);
        chk("rst_bcast_data", bcast_data, 0);
        chk("rst_bcast_addr", LW'(bcast_addr), 0);

        // Single request, zero-wait memory.
        cv[2] = 1'b1; ca[2] = 15'h0123; drive();
        fetch(0, 0, -1, -1, 1'b0, {20{8'hA5}});

        // All clients requesting continuously: grant order 0,1,2,3,0.
        for (int i = 0; i < N; i++) begin
            cv[i] = 1'b1;
            ca[i] = AW'(16'h1000 + i * 16'h0111);
        end
        rst = 1'b1; rr = N - 1; drive();
        cyc(); rst = 1'b0;
        for (int k = 0; k < 5; k++) fetch(0, 0, -1, -1, 1'b1, rnd_line());
        clear_clients();
        cyc();

        // Shared line served by one memory read.
        cv[0] = 1'b1; ca[0] = 15'h0040;
        cv[3] = 1'b1; ca[3] = 15'h0040;
        drive();
        cnt0 = mem_cnt;
        fetch(0, 0, -1, -1, 1'b0, rnd_line());
        chk("shared_mem_cnt", LW'(mem_cnt - cnt0), 1);
        cyc(); #1;
        chk("shared_no_refetch", LW'(mem_req_valid), 0);

        // Memory backpressure and long response latency.
        cv[1] = 1'b1; ca[1] = 15'h2BCD; drive();
        fetch(7, 10, -1, -1, 1'b0, rnd_line());

        // Requester withdraws during WAIT; client 2 is next.
        rst = 1'b1; rr = N - 1;
        cv[1] = 1'b1; ca[1] = 15'h0111;
        cv[2] = 1'b1; ca[2] = 15'h0222;
        drive();
        cyc(); rst = 1'b0;
        fetch(0, 2, 1, -1, 1'b0, rnd_line());
        fetch(0, 0, -1, -1, 1'b0, rnd_line());

        // Late arrival in the broadcast cycle still gets served.
        cv[0] = 1'b1; ca[0] = 15'h3456; drive();
        fetch(1, 1, -1, 3, 1'b0, rnd_line());

        // Reset while waiting for memory: the late response is dropped.
        clear_clients();
        cv[3] = 1'b1; ca[3] = 15'h0777; drive();
        cyc(); #1;
        chk("rstw_req", LW'(mem_req_valid), 1);
        mem_req_ready = 1'b1;
        cyc();
        mem_req_ready = 1'b0;
        clear_clients();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        rr = N - 1;
        #1;
        chk("rstw_no_req", LW'(mem_req_valid), 0);
        chk("rstw_idle", LW'(busy), 0);
        mem_rsp_valid = 1'b1; mem_rsp_data = rnd_line();
        cyc();
        mem_rsp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("rstw_no_bcast", LW'(bcast_valid), 0);
            chk("rstw_busy", LW'(busy), 0);
            cyc();
        end
        cv[0] = 1'b1; ca[0] = 15'h0AAA;
        cv[2] = 1'b1; ca[2] = 15'h0BBB;
        drive();
        fetch(0, 0, -1, -1, 1'b0, rnd_line());
        fetch(0, 0, -1, -1, 1'b0, rnd_line());

        // Randomized traffic, including duplicate addresses, withdrawals and late arrivals.
        for (int it = 0; it < 40; it++) begin
            nv = 0;
            for (int i = 0; i < N; i++) begin
                if (!cv[i] || $urandom_range(0, 3) == 0) begin
                    cv[i] = ($urandom_range(0, 1) == 1);
                    ca[i] = AW'($urandom);
                end
                if (i > 0 && $urandom_range(0, 3) == 0) ca[i] = ca[$urandom_range(0, i - 1)];
                if (cv[i]) nv++;
            end
            if (nv == 0) cv[$urandom_range(0, N - 1)] = 1'b1;
            drive();
            fetch($urandom_range(0, 3), $urandom_range(0, 4),
                  ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, N - 1)) : -1,
                  ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, N - 1)) : -1,
                  $urandom_range(0, 1) == 1, rnd_line());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests %0d failures %0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cache_line_fetch_arbiter_broadcast.md
Name: cache_line_fetch_arbiter_broadcast

Overview:
- Sits directly downstream of the per-block directly-mapped broadcast caches and upstream of the shared backing memory.
- Collects line-fetch requests from NCLIENTS caches, arbitrates them round-robin and issues one line read at a time to memory.
- Broadcasts every returned line (address plus data) to all caches, so a miss in one cache fills the others and satisfies any other waiting requester of the same line.

Parameters:
- NCLIENTS, 4, number of cache clients.
- DWIDTH, 5, word width in bits.
- BLOCK_WIDTH_BITS, 5, log2 of words per line; line width LINE_W = DWIDTH*2**BLOCK_WIDTH_BITS.
- LINE_ADDR_WIDTH, 15, line address width (cache ADDR_IN_WIDTH - BLOCK_WIDTH_BITS).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NCLIENTS  per-client line-fetch request.
- req_addr  in  NCLIENTS*LINE_ADDR_WIDTH  per-client line address; client i occupies bits [i*LINE_ADDR_WIDTH +: LINE_ADDR_WIDTH].
- req_ready  out  NCLIENTS  per-client acceptance; high for exactly the broadcast cycle.
- bcast_addr  out  LINE_ADDR_WIDTH  line address being broadcast.
- bcast_valid  out  1  broadcast strobe.
- bcast_data  out  LINE_W  line data; valid the cycle after bcast_valid.
- mem_req_valid  out  1  memory read request.
- mem_req_addr  out  LINE_ADDR_WIDTH  memory line address.
- mem_req_ready  in  1  memory accepts the request.
- mem_rsp_valid  in  1  memory response strobe (1-cycle pulse).
- mem_rsp_data  in  LINE_W  returned line.
- busy  out  1  high whenever state != S_IDLE.

Behaviour:
- Reset values:
  - state = S_IDLE; rr_ptr = NCLIENTS-1, so client 0 has first priority.
  - All outputs 0, including req_ready, bcast_valid, mem_req_valid and busy.
  - bcast_data register cleared to 0.
- S_IDLE:
  - If any req_valid is high, grant the first valid client searching rr_ptr+1, rr_ptr+2, … modulo NCLIENTS.
  - Capture that client's index and req_addr into addr_saved, then go to S_REQ.
  - Otherwise stay in S_IDLE.
  - mem_rsp_valid is ignored in S_IDLE.
- S_REQ:
  - mem_req_valid = 1 and mem_req_addr = addr_saved, both held stable until mem_req_ready.
  - On mem_req_valid && mem_req_ready, set rr_ptr = granted index and go to S_WAIT.
- S_WAIT:
  - On mem_rsp_valid, register mem_rsp_data into line_reg and go to S_BCAST.
  - Memory latency is unbounded; there is no timeout.
- S_BCAST (exactly 1 cycle):
  - bcast_valid = 1 and bcast_addr = addr_saved.
  - req_ready[i] = req_valid[i] && req_addr[i] == addr_saved, for every i. Multiple readies in the same cycle are legal.
  - If the original requester has dropped or changed its address, the broadcast still occurs and its ready stays 0.
  - Next state is S_HOLD.
- S_HOLD (exactly 1 cycle):
  - bcast_data = line_reg is the cycle in which caches write their line (the cycle after ready/broadcast).
  - Next state is S_IDLE.
  - line_reg is only overwritten on the next mem_rsp_valid accepted in S_WAIT, so bcast_data stays stable at least through S_HOLD.
- Throughput:
  - Minimum of 5 cycles per fetch with zero-latency memory: IDLE→REQ→WAIT→BCAST→HOLD.
  - One outstanding memory request at a time.
- Fairness:
  - Round-robin; a continuously requesting client is served within NCLIENTS fetches.
  - Requests are not deduplicated at arbitration time; dedup happens through the broadcast-match on req_ready.
- Simultaneous events:
  - New requests arriving during REQ, WAIT, BCAST or HOLD are not sampled until the next S_IDLE.
  - A client whose address matches during S_BCAST is served by that broadcast, even if it asserted req_valid in that same cycle.
- Reset mid-operation:
  - Return to S_IDLE immediately; any in-flight memory response is dropped.
  - mem_req_valid deasserts in the cycle after rst.
- Widths: the arbiter performs no arithmetic on addresses. The rr_ptr width is $clog2(NCLIENTS), with a minimum of 1 bit.

Test Plan:
- Single request: client 2 sends addr 0x0123, memory has 0 wait and returns 0xA5… → req_ready = 4'b0100 with bcast_valid and bcast_addr = 0x0123 in one cycle; bcast_data = returned line in the next cycle; busy drops afterwards.
- Round-robin: all 4 clients request distinct addrs continuously from reset → grant order 0,1,2,3,0; each req_ready is a 1-cycle pulse.
- Shared line: clients 0 and 3 both request 0x0040 → a single mem_req (count = 1); req_ready = 4'b1001 in the same cycle.
- Memory backpressure: mem_req_ready held low for 7 cycles, then response latency of 10 cycles → mem_req_addr stable throughout; no bcast_valid until 1 cycle after mem_rsp_valid.
- Requester withdraw: client 1 drops req_valid during S_WAIT → broadcast still issued with req_ready = 0; the next fetch grants client 2 if it is pending.
- Reset in S_WAIT: assert rst, then deliver mem_rsp_valid → no bcast_valid occurs; state is S_IDLE; a fresh request is served with client 0 priority.
